// File: rtl/cla_adder_64.sv
// 64-bit hierarchical carry-lookahead adder with a registered {cout,sum}.
// Bit p/g -> 4-bit group G/P -> 4 super-groups of 4 groups -> top lookahead.
// Every carry is produced by a flattened lookahead expression; no inter-group ripple.
module cla_adder_64 #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int NSUP = NGRP / GROUP;

  // Two-level lookahead over four (g,p) pairs: c[0] is the carry in, c[4] the carry out.
  function automatic logic [4:0] lac4(input logic [3:0] g4, input logic [3:0] p4,
                                      input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g4[0] | (p4[0] & ci);
    c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
         | (p4[2] & p4[1] & p4[0] & ci);
    c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]) | (p4[3] & p4[2] & p4[1] & p4[0] & ci);
    return c;
  endfunction

  // Block generate of four (g,p) pairs, independent of the carry in.
  function automatic logic gen4(input logic [3:0] g4, input logic [3:0] p4);
    return g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]);
  endfunction

  logic [WIDTH-1:0] p, g, c;
  logic [NGRP-1:0]  grp_g, grp_p, grp_c;
  logic [NSUP-1:0]  sup_g, sup_p;
  logic [NSUP:0]    sup_c;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  // Lookahead tree: generate/propagate upwards, carries back down to every bit.
  always_comb begin
    logic [4:0] t;
    t     = '0;
    p     = a ^ b;
    g     = a & b;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    sup_g = '0;
    sup_p = '0;
    c     = '0;

    for (int i = 0; i < NGRP; i++) begin
      grp_g[i] = gen4(g[GROUP*i +: GROUP], p[GROUP*i +: GROUP]);
      grp_p[i] = &p[GROUP*i +: GROUP];
    end

    for (int s = 0; s < NSUP; s++) begin
      sup_g[s] = gen4(grp_g[GROUP*s +: GROUP], grp_p[GROUP*s +: GROUP]);
      sup_p[s] = &grp_p[GROUP*s +: GROUP];
    end

    // Top level: super-group carry-ins and the final carry out in one lookahead step.
    sup_c = lac4(sup_g, sup_p, cin);

    for (int s = 0; s < NSUP; s++) begin
      t = lac4(grp_g[GROUP*s +: GROUP], grp_p[GROUP*s +: GROUP], sup_c[s]);
      grp_c[GROUP*s +: GROUP] = t[3:0];
    end

    for (int i = 0; i < NGRP; i++) begin
      t = lac4(g[GROUP*i +: GROUP], p[GROUP*i +: GROUP], grp_c[i]);
      c[GROUP*i +: GROUP] = t[3:0];
    end

    sum_d  = p ^ c;
    cout_d = sup_c[NSUP];
  end

  // Output register; reset wins over the result computed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_adder_64.sv
// Scoreboard bench for cla_adder_64: the driver pushes the expected {cout,sum}
// for every edge it drives, the monitor pops and compares one result per cycle.
module tb_cla_adder_64;

  logic        clk;
  logic        rst;
  logic [63:0] a, b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;

  typedef struct {
    logic [64:0] exp;
    int          id;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  vec_id = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  cla_adder_64 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one vector on the falling edge; the next rising edge captures it.
  task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                       input logic r, input logic [64:0] exp);
    sb_t e;
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = ci;
    rst = r;
    e.exp = exp;
    e.id  = vec_id;
    vec_id++;
    sb_q.push_back(e);
  endtask

  // Monitor: each registered result is compared against the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({cout, sum} !== e.exp) begin
          bad++;
          $display("FAIL vec%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                   e.id, cout, sum, e.exp[64], e.exp[63:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    rst = 1'b1;
    a   = ONES;
    b   = ONES;
    cin = 1'b0;

    // Reset held for two edges with all-ones operands, then release.
    drive(ONES, ONES, 1'b0, 1'b1, 65'h0);
    drive(ONES, ONES, 1'b0, 1'b1, 65'h0);
    drive(ONES, ONES, 1'b0, 1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});

    // Full carry chain, group boundaries, max and zero.
    drive(ONES, 64'h0, 1'b1, 1'b0, {1'b1, 64'h0});
    drive(64'h0000_0000_0000_000F, 64'h1, 1'b0, 1'b0, {1'b0, 64'h10});
    drive(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, {1'b0, 64'h0001_0000_0000_0000});
    drive(ONES, ONES, 1'b1, 1'b0, {1'b1, ONES});
    drive(64'h0, 64'h0, 1'b0, 1'b0, 65'h0);

    // Back-to-back distinct vectors, then a super-group boundary carry.
    drive(64'h1, 64'h2, 1'b0, 1'b0, {1'b0, 64'h3});
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, {1'b1, 64'h1});
    drive(64'h1234, 64'h1111, 1'b1, 1'b0, {1'b0, 64'h2346});
    drive(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {1'b0, 64'h0000_0001_0000_0000});

    // Reset mid-stream discards the pending result, then resumes.
    drive(64'h5, 64'h5, 1'b0, 1'b1, 65'h0);
    drive(64'h5, 64'h5, 1'b0, 1'b0, {1'b0, 64'hA});

    // Random vectors against a 65-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      drive(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {64'h0, rc});
    end

    // Let the last result drain, then confirm nothing is left unchecked.
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
